morse_tx_sequencer: RTL and testbench

//  Keying controller for the letter-to-Morse lookup ROM. Accepts one letter per

---
 rtl/morse_pkg.sv | 46 ++++
 rtl/morse_unit_timer.sv | 26 ++
 rtl/morse_tx_sequencer.sv | 155 +++++++++++++++
 tb/tb_morse_tx_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keying sequencer: letter codes, element
// lengths, gap widths in units, and the sequencer state encoding.
package morse_pkg;

  typedef enum logic [4:0] {
    L_SPACE = 5'd0,
    L_A = 5'd1,  L_B = 5'd2,  L_C = 5'd3,  L_D = 5'd4,  L_E = 5'd5,
    L_F = 5'd6,  L_G = 5'd7,  L_H = 5'd8,  L_I = 5'd9,  L_J = 5'd10,
    L_K = 5'd11, L_L = 5'd12, L_M = 5'd13, L_N = 5'd14, L_O = 5'd15,
    L_P = 5'd16, L_Q = 5'd17, L_R = 5'd18, L_S = 5'd19, L_T = 5'd20,
    L_U = 5'd21, L_V = 5'd22, L_W = 5'd23, L_X = 5'd24, L_Y = 5'd25,
    L_Z = 5'd26
  } letter_t;

  // Durations in Morse units.
  localparam logic [2:0] UNITS_DOT  = 3'd1;
  localparam logic [2:0] UNITS_DASH = 3'd3;
  localparam logic [2:0] UNITS_EL   = 3'd1;
  localparam logic [2:0] UNITS_LTR  = 3'd3;
  localparam logic [2:0] UNITS_WORD = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_ROM_WAIT = 3'd2,
    ST_KEY_ON   = 3'd3,
    ST_EL_GAP   = 3'd4,
    ST_LTR_GAP  = 3'd5,
    ST_SPACE    = 3'd6
  } morse_state_t;

  // Number of elements in each letter; 0 marks space and invalid codes.
  function automatic logic [2:0] len_of(input logic [4:0] alpha);
    logic [2:0] len;
    case (alpha)
      L_E, L_T:                                    len = 3'd1;
      L_A, L_I, L_M, L_N:                          len = 3'd2;
      L_D, L_G, L_K, L_O, L_R, L_S, L_U, L_W:      len = 3'd3;
      L_B, L_C, L_F, L_H, L_J, L_L, L_P, L_Q,
      L_V, L_X, L_Y, L_Z:                          len = 3'd4;
      default:                                     len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter in multiples of the Morse unit; holds at zero.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [2:0]       units,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(units) * CNT_W'(UNIT_CYCLES) - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/morse_tx_sequencer.sv
// Accepts one letter per handshake, fetches its pattern from the lookup ROM
// and keys it out with standard Morse element, letter and word timing.
module morse_tx_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [4:0]   in_alpha,
  output logic         in_ready,
  output logic [1:0]   rom_len_sel,
  output logic [4:0]   rom_alpha,
  input  logic [3:0]   rom_code,
  output logic         key_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output morse_state_t fsm_state
);

  // Handshake: a letter is taken on a rising edge where in_valid and in_ready
  // are both high; in_ready is high only in IDLE, so in_valid is ignored while
  // busy and the source must keep holding it until it is taken.

  morse_state_t     state;
  logic [3:0]       pattern;
  logic [1:0]       idx;
  logic [2:0]       alpha_len;
  logic             tmr_load;
  logic [2:0]       tmr_units;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_zero;

  assign alpha_len = len_of(in_alpha);
  assign fsm_state = state;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .units(tmr_units),
    .count(tmr_count),
    .zero (tmr_zero)
  );

  // Timer is reloaded on the edge that enters each timed state.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_units = 3'd0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_alpha == L_SPACE) begin
          tmr_load  = 1'b1;
          tmr_units = UNITS_WORD;
        end
      end
      ST_ROM_WAIT: begin
        tmr_load  = 1'b1;
        tmr_units = rom_code[rom_len_sel] ? UNITS_DASH : UNITS_DOT;
      end
      ST_KEY_ON: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_units = (idx == 2'd0) ? UNITS_LTR : UNITS_EL;
        end
      end
      ST_EL_GAP: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_units = pattern[idx - 2'd1] ? UNITS_DASH : UNITS_DOT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pattern     <= 4'd0;
      idx         <= 2'd0;
      in_ready    <= 1'b1;
      rom_len_sel <= 2'd0;
      rom_alpha   <= 5'd0;
      key_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_alpha == L_SPACE) begin
              state    <= ST_SPACE;
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end else if (alpha_len != 3'd0) begin
              state       <= ST_LOOKUP;
              rom_alpha   <= in_alpha;
              rom_len_sel <= 2'(alpha_len - 3'd1);
              busy        <= 1'b1;
              in_ready    <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOOKUP: state <= ST_ROM_WAIT;
        ST_ROM_WAIT: begin
          pattern <= rom_code;
          idx     <= rom_len_sel;
          key_out <= 1'b1;
          state   <= ST_KEY_ON;
        end
        ST_KEY_ON: begin
          if (tmr_zero) begin
            key_out <= 1'b0;
            state   <= (idx == 2'd0) ? ST_LTR_GAP : ST_EL_GAP;
          end
        end
        ST_EL_GAP: begin
          if (tmr_zero) begin
            idx     <= idx - 2'd1;
            key_out <= 1'b1;
            state   <= ST_KEY_ON;
          end
        end
        ST_LTR_GAP, ST_SPACE: begin
          // done marks the last cycle of the trailing gap.
          done <= (tmr_count == CNT_W'(1));
          if (tmr_zero) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          key_out  <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Bench for the Morse keying sequencer with a registered lookup-ROM model and
// a per-cycle expected key/done waveform derived from dot/dash strings.
module tb_morse_tx_sequencer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_alpha;
  logic       in_ready;
  logic [1:0] rom_len_sel;
  logic [4:0] rom_alpha;
  logic [3:0] rom_code;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] fsm_state;

  int tests = 0;
  int fails = 0;
  logic [3:0] rom_junk = 4'd0;
  logic [4:0] last_alpha = 5'd0;
  logic [1:0] last_len = 2'd0;

  always #5 clk = ~clk;

  morse_tx_sequencer #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_alpha   (in_alpha),
    .in_ready   (in_ready),
    .rom_len_sel(rom_len_sel),
    .rom_alpha  (rom_alpha),
    .rom_code   (rom_code),
    .key_out    (key_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  function automatic string code_str(input int a);
    case (a)
      1: return ".-";    2: return "-...";  3: return "-.-.";  4: return "-..";
      5: return ".";     6: return "..-.";  7: return "--.";   8: return "....";
      9: return "..";   10: return ".---"; 11: return "-.-";  12: return ".-..";
     13: return "--";   14: return "-.";   15: return "---";  16: return ".--.";
     17: return "--.-"; 18: return ".-.";  19: return "...";  20: return "-";
     21: return "..-";  22: return "...-"; 23: return ".--";  24: return "-..-";
     25: return "-.--"; 26: return "--..";
      default: return "";
    endcase
  endfunction

  // ROM image: first symbol in bit[L-1], unused upper bits filled with junk.
  function automatic logic [3:0] build_code(input logic [4:0] a, input logic [3:0] junk);
    string s;
    logic [3:0] c;
    s = code_str(int'(a));
    c = junk;
    for (int i = 0; i < s.len(); i++) c[s.len() - 1 - i] = (s.getc(i) == "-");
    return c;
  endfunction

  always @(posedge clk) rom_code <= build_code(rom_alpha, rom_junk);

  task automatic run_letter(input logic [4:0] a, input logic hold, input logic [4:0] next_a);
    string s;
    logic [1:0] exp_q[$];
    int wait_cnt;
    logic [4:0] obs;
    logic [4:0] want;
    in_alpha = a;
    in_valid = 1'b1;
    rom_junk = 4'($urandom_range(0, 15));
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 400) begin
      @(negedge clk);
      wait_cnt++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout alpha=%0d in_ready=%b want 1", a, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) in_alpha = next_a;
    else in_valid = 1'b0;
    // Expected {key, done} for every busy cycle following the accept edge.
    if (a == 5'd0) begin
      for (int i = 0; i < 7 * U; i++) exp_q.push_back(2'b00);
    end else begin
      s = code_str(int'(a));
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      for (int e = 0; e < s.len(); e++) begin
        for (int i = 0; i < ((s.getc(e) == "-") ? 3 * U : U); i++) exp_q.push_back(2'b10);
        for (int i = 0; i < ((e == s.len() - 1) ? 3 * U : U); i++) exp_q.push_back(2'b00);
      end
      last_alpha = a;
      last_len = 2'(s.len() - 1);
    end
    exp_q[exp_q.size() - 1] = 2'b01;
    tests++;
    if (rom_alpha !== last_alpha || rom_len_sel !== last_len) begin
      fails++;
      $display("FAIL rom_select alpha=%0d got alpha=%0d len_sel=%0d want alpha=%0d len_sel=%0d",
               a, rom_alpha, rom_len_sel, last_alpha, last_len);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      obs  = {key_out, done, busy, in_ready, err};
      want = {exp_q[k], 3'b100};
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL seq alpha=%0d cycle=%0d key/done/busy/rdy/err got %b want %b",
                 a, k + 1, obs, want);
      end
    end
    @(negedge clk);
    obs = {key_out, done, busy, in_ready, err};
    tests++;
    if (obs !== 5'b00010) begin
      fails++;
      $display("FAIL idle_after alpha=%0d key/done/busy/rdy/err got %b want 00010", a, obs);
    end
  endtask

  task automatic run_invalid(input logic [4:0] a);
    logic [4:0] obs;
    in_alpha = a;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    obs = {err, busy, key_out, in_ready, done};
    tests++;
    if (obs !== 5'b10010 || rom_alpha !== last_alpha) begin
      fails++;
      $display("FAIL invalid_pulse alpha=%0d err/busy/key/rdy/done got %b want 10010 rom_alpha=%0d want %0d",
               a, obs, rom_alpha, last_alpha);
    end
    @(negedge clk);
    obs = {err, busy, key_out, in_ready, done};
    tests++;
    if (obs !== 5'b00010) begin
      fails++;
      $display("FAIL invalid_after alpha=%0d err/busy/key/rdy/done got %b want 00010", a, obs);
    end
  endtask

  task automatic check_reset_values(input string name);
    logic [13:0] obs;
    obs = {key_out, busy, done, err, in_ready, rom_len_sel, rom_alpha, fsm_state};
    tests++;
    if (obs !== {5'b00001, 2'd0, 5'd0, 3'd0}) begin
      fails++;
      $display("FAIL %s key/busy/done/err/rdy/len/alpha/state got %b want 00001_00_00000_000", name, obs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_alpha = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_letter_e();
    run_letter(5'd5, 1'b0, 5'd0);
  endtask

  task automatic test_letter_a();
    run_letter(5'd1, 1'b0, 5'd0);
  endtask

  task automatic test_back_to_back();
    run_letter(5'd17, 1'b1, 5'd20);
    run_letter(5'd20, 1'b0, 5'd0);
  endtask

  task automatic test_space();
    run_letter(5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_invalid();
    run_invalid(5'd30);
    run_invalid(5'd27);
  endtask

  task automatic test_reset_mid_letter();
    int wait_cnt;
    in_alpha = 5'd15;
    in_valid = 1'b1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 400) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (key_out !== 1'b1) begin
      fails++;
      $display("FAIL mid_dash_key got %b want 1", key_out);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("reset_mid_letter");
    @(negedge clk);
    rst_n = 1'b1;
    last_alpha = 5'd0;
    last_len = 2'd0;
    @(negedge clk);
    check_reset_values("reset_release");
    run_letter(5'd5, 1'b0, 5'd0);
  endtask

  task automatic test_random();
    logic [4:0] cur;
    logic [4:0] nxt;
    logic hold;
    cur = 5'($urandom_range(0, 31));
    for (int n = 0; n < 16; n++) begin
      nxt  = 5'($urandom_range(0, 26));
      hold = 1'($urandom_range(0, 1));
      if (cur > 5'd26) begin
        run_invalid(cur);
        cur = 5'($urandom_range(0, 31));
      end else begin
        run_letter(cur, hold, nxt);
        cur = hold ? nxt : 5'($urandom_range(0, 31));
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_letter_e();
    test_letter_a();
    test_back_to_back();
    test_space();
    test_invalid();
    test_reset_mid_letter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
